// File: rtl/pdp11_inst_encoder_pkg.sv
// rtl/pdp11_inst_encoder_pkg.sv - shared PDP-11 encoder types, base opcodes and helpers
package pdp11_inst_encoder_pkg;

   typedef enum logic [6:0] {
      M_MOV, M_MOVB, M_CMP, M_CMPB, M_BIT, M_BITB, M_BIC, M_BICB, M_BIS, M_BISB, M_ADD, M_SUB,
      M_BR, M_BNE, M_BEQ, M_BGE, M_BLT, M_BGT, M_BLE, M_BPL, M_BMI, M_BHI, M_BLOS,
      M_BVC, M_BVS, M_BCC, M_BCS,
      M_CLR, M_CLRB, M_COM, M_COMB, M_INC, M_INCB, M_DEC, M_DECB, M_NEG, M_NEGB,
      M_ADC, M_ADCB, M_SBC, M_SBCB, M_TST, M_TSTB, M_ROR, M_RORB, M_ROL, M_ROLB,
      M_ASR, M_ASRB, M_ASL, M_ASLB,
      M_JMP, M_SWAB, M_JSR, M_RTS,
      M_HALT, M_NOP, M_CLC, M_CLV, M_CLZ, M_CLN, M_SEC, M_SEV, M_SEZ, M_SEN
   } opcode_mnemonic;

   typedef enum logic [2:0] {
      CLS_DOP, CLS_SOP, CLS_JMP, CLS_BR, CLS_JSR, CLS_RTS, CLS_PSW, CLS_SYS
   } op_class_t;

   typedef enum logic [1:0] {
      ST_IDLE, ST_OPW, ST_SRCX, ST_DSTX
   } enc_state_t;

   localparam logic [15:0] BYTE_BIT = 16'o100000;

   localparam logic [15:0] OP_MOV  = 16'o010000;
   localparam logic [15:0] OP_CMP  = 16'o020000;
   localparam logic [15:0] OP_BIT  = 16'o030000;
   localparam logic [15:0] OP_BIC  = 16'o040000;
   localparam logic [15:0] OP_BIS  = 16'o050000;
   localparam logic [15:0] OP_ADD  = 16'o060000;
   localparam logic [15:0] OP_SUB  = 16'o160000;

   localparam logic [15:0] OP_BR   = 16'o000400;
   localparam logic [15:0] OP_BNE  = 16'o001000;
   localparam logic [15:0] OP_BEQ  = 16'o001400;
   localparam logic [15:0] OP_BGE  = 16'o002000;
   localparam logic [15:0] OP_BLT  = 16'o002400;
   localparam logic [15:0] OP_BGT  = 16'o003000;
   localparam logic [15:0] OP_BLE  = 16'o003400;
   localparam logic [15:0] OP_BPL  = 16'o100000;
   localparam logic [15:0] OP_BMI  = 16'o100400;
   localparam logic [15:0] OP_BHI  = 16'o101000;
   localparam logic [15:0] OP_BLOS = 16'o101400;
   localparam logic [15:0] OP_BVC  = 16'o102000;
   localparam logic [15:0] OP_BVS  = 16'o102400;
   localparam logic [15:0] OP_BCC  = 16'o103000;
   localparam logic [15:0] OP_BCS  = 16'o103400;

   localparam logic [15:0] OP_CLR  = 16'o005000;
   localparam logic [15:0] OP_COM  = 16'o005100;
   localparam logic [15:0] OP_INC  = 16'o005200;
   localparam logic [15:0] OP_DEC  = 16'o005300;
   localparam logic [15:0] OP_NEG  = 16'o005400;
   localparam logic [15:0] OP_ADC  = 16'o005500;
   localparam logic [15:0] OP_SBC  = 16'o005600;
   localparam logic [15:0] OP_TST  = 16'o005700;
   localparam logic [15:0] OP_ROR  = 16'o006000;
   localparam logic [15:0] OP_ROL  = 16'o006100;
   localparam logic [15:0] OP_ASR  = 16'o006200;
   localparam logic [15:0] OP_ASL  = 16'o006300;
   localparam logic [15:0] OP_JMP  = 16'o000100;
   localparam logic [15:0] OP_SWAB = 16'o000300;
   localparam logic [15:0] OP_JSR  = 16'o004000;
   localparam logic [15:0] OP_RTS  = 16'o000200;

   localparam logic [15:0] OP_HALT = 16'o000000;
   localparam logic [15:0] OP_NOP  = 16'o000240;
   localparam logic [15:0] OP_CLC  = 16'o000241;
   localparam logic [15:0] OP_CLV  = 16'o000242;
   localparam logic [15:0] OP_CLZ  = 16'o000244;
   localparam logic [15:0] OP_CLN  = 16'o000250;
   localparam logic [15:0] OP_SEC  = 16'o000261;
   localparam logic [15:0] OP_SEV  = 16'o000262;
   localparam logic [15:0] OP_SEZ  = 16'o000264;
   localparam logic [15:0] OP_SEN  = 16'o000270;

   // Indexed modes always carry a word; autoincrement through PC is immediate/absolute.
   function automatic logic needs_ext(input logic [2:0] mode, input logic [2:0] rn);
      return (mode == 3'd6) || (mode == 3'd7) ||
             (((mode == 3'd2) || (mode == 3'd3)) && (rn == 3'd7));
   endfunction

endpackage

// File: rtl/pdp11_opcode_rom.sv
// rtl/pdp11_opcode_rom.sv - maps a mnemonic to its base opcode word and operand class
module pdp11_opcode_rom
   import pdp11_inst_encoder_pkg::*;
(
   input  opcode_mnemonic mnem_i,
   output logic [15:0]    base_o,
   output op_class_t      cls_o
);

   always_comb begin
      base_o = OP_HALT;
      cls_o  = CLS_SYS;
      case (mnem_i)
         M_MOV:  begin base_o = OP_MOV;             cls_o = CLS_DOP; end
         M_MOVB: begin base_o = OP_MOV | BYTE_BIT;  cls_o = CLS_DOP; end
         M_CMP:  begin base_o = OP_CMP;             cls_o = CLS_DOP; end
         M_CMPB: begin base_o = OP_CMP | BYTE_BIT;  cls_o = CLS_DOP; end
         M_BIT:  begin base_o = OP_BIT;             cls_o = CLS_DOP; end
         M_BITB: begin base_o = OP_BIT | BYTE_BIT;  cls_o = CLS_DOP; end
         M_BIC:  begin base_o = OP_BIC;             cls_o = CLS_DOP; end
         M_BICB: begin base_o = OP_BIC | BYTE_BIT;  cls_o = CLS_DOP; end
         M_BIS:  begin base_o = OP_BIS;             cls_o = CLS_DOP; end
         M_BISB: begin base_o = OP_BIS | BYTE_BIT;  cls_o = CLS_DOP; end
         M_ADD:  begin base_o = OP_ADD;             cls_o = CLS_DOP; end
         M_SUB:  begin base_o = OP_SUB;             cls_o = CLS_DOP; end
         M_BR:   begin base_o = OP_BR;              cls_o = CLS_BR;  end
         M_BNE:  begin base_o = OP_BNE;             cls_o = CLS_BR;  end
         M_BEQ:  begin base_o = OP_BEQ;             cls_o = CLS_BR;  end
         M_BGE:  begin base_o = OP_BGE;             cls_o = CLS_BR;  end
         M_BLT:  begin base_o = OP_BLT;             cls_o = CLS_BR;  end
         M_BGT:  begin base_o = OP_BGT;             cls_o = CLS_BR;  end
         M_BLE:  begin base_o = OP_BLE;             cls_o = CLS_BR;  end
         M_BPL:  begin base_o = OP_BPL;             cls_o = CLS_BR;  end
         M_BMI:  begin base_o = OP_BMI;             cls_o = CLS_BR;  end
         M_BHI:  begin base_o = OP_BHI;             cls_o = CLS_BR;  end
         M_BLOS: begin base_o = OP_BLOS;            cls_o = CLS_BR;  end
         M_BVC:  begin base_o = OP_BVC;             cls_o = CLS_BR;  end
         M_BVS:  begin base_o = OP_BVS;             cls_o = CLS_BR;  end
         M_BCC:  begin base_o = OP_BCC;             cls_o = CLS_BR;  end
         M_BCS:  begin base_o = OP_BCS;             cls_o = CLS_BR;  end
         M_CLR:  begin base_o = OP_CLR;             cls_o = CLS_SOP; end
         M_CLRB: begin base_o = OP_CLR | BYTE_BIT;  cls_o = CLS_SOP; end
         M_COM:  begin base_o = OP_COM;             cls_o = CLS_SOP; end
         M_COMB: begin base_o = OP_COM | BYTE_BIT;  cls_o = CLS_SOP; end
         M_INC:  begin base_o = OP_INC;             cls_o = CLS_SOP; end
         M_INCB: begin base_o = OP_INC | BYTE_BIT;  cls_o = CLS_SOP; end
         M_DEC:  begin base_o = OP_DEC;             cls_o = CLS_SOP; end
         M_DECB: begin base_o = OP_DEC | BYTE_BIT;  cls_o = CLS_SOP; end
         M_NEG:  begin base_o = OP_NEG;             cls_o = CLS_SOP; end
         M_NEGB: begin base_o = OP_NEG | BYTE_BIT;  cls_o = CLS_SOP; end
         M_ADC:  begin base_o = OP_ADC;             cls_o = CLS_SOP; end
         M_ADCB: begin base_o = OP_ADC | BYTE_BIT;  cls_o = CLS_SOP; end
         M_SBC:  begin base_o = OP_SBC;             cls_o = CLS_SOP; end
         M_SBCB: begin base_o = OP_SBC | BYTE_BIT;  cls_o = CLS_SOP; end
         M_TST:  begin base_o = OP_TST;             cls_o = CLS_SOP; end
         M_TSTB: begin base_o = OP_TST | BYTE_BIT;  cls_o = CLS_SOP; end
         M_ROR:  begin base_o = OP_ROR;             cls_o = CLS_SOP; end
         M_RORB: begin base_o = OP_ROR | BYTE_BIT;  cls_o = CLS_SOP; end
         M_ROL:  begin base_o = OP_ROL;             cls_o = CLS_SOP; end
         M_ROLB: begin base_o = OP_ROL | BYTE_BIT;  cls_o = CLS_SOP; end
         M_ASR:  begin base_o = OP_ASR;             cls_o = CLS_SOP; end
         M_ASRB: begin base_o = OP_ASR | BYTE_BIT;  cls_o = CLS_SOP; end
         M_ASL:  begin base_o = OP_ASL;             cls_o = CLS_SOP; end
         M_ASLB: begin base_o = OP_ASL | BYTE_BIT;  cls_o = CLS_SOP; end
         M_JMP:  begin base_o = OP_JMP;             cls_o = CLS_JMP; end
         M_SWAB: begin base_o = OP_SWAB;            cls_o = CLS_SOP; end
         M_JSR:  begin base_o = OP_JSR;             cls_o = CLS_JSR; end
         M_RTS:  begin base_o = OP_RTS;             cls_o = CLS_RTS; end
         M_HALT: begin base_o = OP_HALT;            cls_o = CLS_SYS; end
         M_NOP:  begin base_o = OP_NOP;             cls_o = CLS_PSW; end
         M_CLC:  begin base_o = OP_CLC;             cls_o = CLS_PSW; end
         M_CLV:  begin base_o = OP_CLV;             cls_o = CLS_PSW; end
         M_CLZ:  begin base_o = OP_CLZ;             cls_o = CLS_PSW; end
         M_CLN:  begin base_o = OP_CLN;             cls_o = CLS_PSW; end
         M_SEC:  begin base_o = OP_SEC;             cls_o = CLS_PSW; end
         M_SEV:  begin base_o = OP_SEV;             cls_o = CLS_PSW; end
         M_SEZ:  begin base_o = OP_SEZ;             cls_o = CLS_PSW; end
         M_SEN:  begin base_o = OP_SEN;             cls_o = CLS_PSW; end
         default: begin base_o = OP_HALT;           cls_o = CLS_SYS; end
      endcase
   end

endmodule

// File: rtl/pdp11_inst_encoder.sv
// rtl/pdp11_inst_encoder.sv - sequential PDP-11/20 instruction encoder feeding the loader stream
module pdp11_inst_encoder
   import pdp11_inst_encoder_pkg::*;
#(
   parameter logic [15:0] RESET_ADDR = 16'o000000
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           addr_load,
   input  logic [15:0]    addr_in,
   input  logic           in_valid,
   output logic           in_ready,
   input  opcode_mnemonic mnem,
   input  logic [2:0]     smod,
   input  logic [2:0]     sreg,
   input  logic [2:0]     dmod,
   input  logic [2:0]     dreg,
   input  logic [15:0]    src_x,
   input  logic [15:0]    dst_x,
   input  logic [7:0]     br_ofst,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [15:0]    out_addr,
   output logic [15:0]    out_data,
   output logic           out_last,
   output logic           err
);

   logic [15:0] rom_base;
   op_class_t   rom_cls;

   pdp11_opcode_rom u_rom (
      .mnem_i (mnem),
      .base_o (rom_base),
      .cls_o  (rom_cls)
   );

   logic [15:0] word_d;
   logic        need_src_d;
   logic        need_dst_d;
   logic        illegal_d;

   always_comb begin
      word_d = rom_base;
      case (rom_cls)
         CLS_DOP:          word_d = rom_base | {4'b0, smod, sreg, dmod, dreg};
         CLS_SOP, CLS_JMP: word_d = rom_base | {10'b0, dmod, dreg};
         CLS_JSR:          word_d = rom_base | {7'b0, sreg, dmod, dreg};
         CLS_RTS:          word_d = rom_base | {13'b0, dreg};
         CLS_BR:           word_d = rom_base | {8'b0, br_ofst};
         default:          word_d = rom_base;
      endcase
      need_src_d = (rom_cls == CLS_DOP) && needs_ext(smod, sreg);
      need_dst_d = ((rom_cls == CLS_DOP) || (rom_cls == CLS_SOP) ||
                    (rom_cls == CLS_JMP) || (rom_cls == CLS_JSR)) && needs_ext(dmod, dreg);
      // Register-mode targets have no address to jump to.
      illegal_d  = ((rom_cls == CLS_JMP) || (rom_cls == CLS_JSR)) && (dmod == 3'd0);
   end

   enc_state_t  state_q;
   logic [15:0] addr_q;
   logic        out_valid_q;
   logic [15:0] out_data_q;
   logic        out_last_q;
   logic        err_q;
   logic [15:0] src_x_q;
   logic [15:0] dst_x_q;
   logic        need_src_q;
   logic        need_dst_q;
   logic        word_acc;

   assign word_acc = out_valid_q && out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_q      <= RESET_ADDR;
         out_valid_q <= 1'b0;
         out_data_q  <= 16'd0;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
         src_x_q     <= 16'd0;
         dst_x_q     <= 16'd0;
         need_src_q  <= 1'b0;
         need_dst_q  <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (word_acc) addr_q <= addr_q + 16'd2;
         case (state_q)
            ST_IDLE: begin
               if (addr_load) addr_q <= {addr_in[15:1], 1'b0};
               if (in_valid) begin
                  src_x_q    <= src_x;
                  dst_x_q    <= dst_x;
                  need_src_q <= need_src_d;
                  need_dst_q <= need_dst_d;
                  if (illegal_d) begin
                     err_q <= 1'b1;
                  end else begin
                     state_q     <= ST_OPW;
                     out_valid_q <= 1'b1;
                     out_data_q  <= word_d;
                     out_last_q  <= !need_src_d && !need_dst_d;
                  end
               end
            end
            ST_OPW: begin
               if (word_acc) begin
                  if (need_src_q) begin
                     state_q    <= ST_SRCX;
                     out_data_q <= src_x_q;
                     out_last_q <= !need_dst_q;
                  end else if (need_dst_q) begin
                     state_q    <= ST_DSTX;
                     out_data_q <= dst_x_q;
                     out_last_q <= 1'b1;
                  end else begin
                     state_q     <= ST_IDLE;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                  end
               end
            end
            ST_SRCX: begin
               if (word_acc) begin
                  if (need_dst_q) begin
                     state_q    <= ST_DSTX;
                     out_data_q <= dst_x_q;
                     out_last_q <= 1'b1;
                  end else begin
                     state_q     <= ST_IDLE;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                  end
               end
            end
            ST_DSTX: begin
               if (word_acc) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = out_valid_q;
   assign out_addr  = addr_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign err       = err_q;

endmodule

// File: tb/tb_pdp11_inst_encoder.sv
// tb/tb_pdp11_inst_encoder.sv - table-driven scoreboard bench for pdp11_inst_encoder
module tb_pdp11_inst_encoder;
   import pdp11_inst_encoder_pkg::*;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           addr_load = 1'b0;
   logic [15:0]    addr_in = 16'd0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   opcode_mnemonic mnem = M_HALT;
   logic [2:0]     smod = 3'd0, sreg = 3'd0, dmod = 3'd0, dreg = 3'd0;
   logic [15:0]    src_x = 16'd0, dst_x = 16'd0;
   logic [7:0]     br_ofst = 8'd0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [15:0]    out_addr;
   logic [15:0]    out_data;
   logic           out_last;
   logic           err;

   pdp11_inst_encoder #(.RESET_ADDR(16'o000000)) dut (
      .clk       (clk),
      .reset     (reset),
      .addr_load (addr_load),
      .addr_in   (addr_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mnem      (mnem),
      .smod      (smod),
      .sreg      (sreg),
      .dmod      (dmod),
      .dreg      (dreg),
      .src_x     (src_x),
      .dst_x     (dst_x),
      .br_ofst   (br_ofst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .out_last  (out_last),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      opcode_mnemonic m;
      logic [2:0]     sm, sr, dm, dr;
      logic [15:0]    sx, dx;
      logic [7:0]     bo;
      int             n;
      logic [15:0]    w0, w1, w2;
   } req_t;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
      logic        last;
   } exp_t;

   req_t        tbl[$];
   exp_t        sbq[$];
   exp_t        mon_e;
   int          total = 0;
   int          bad = 0;
   int          err_cnt = 0;
   logic [15:0] exp_addr = 16'd0;
   logic [15:0] a0;

   function automatic req_t mk(input opcode_mnemonic m, input logic [2:0] sm, input logic [2:0] sr,
                               input logic [2:0] dm, input logic [2:0] dr, input logic [15:0] sx,
                               input logic [15:0] dx, input logic [7:0] bo, input int n,
                               input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
      req_t r;
      r.m = m; r.sm = sm; r.sr = sr; r.dm = dm; r.dr = dr;
      r.sx = sx; r.dx = dx; r.bo = bo; r.n = n;
      r.w0 = w0; r.w1 = w1; r.w2 = w2;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %06o expected %06o", nm, act, expv);
      end
   endtask

   task automatic push_word(input logic [15:0] d, input logic l);
      exp_t e;
      e.addr = exp_addr;
      e.data = d;
      e.last = l;
      sbq.push_back(e);
      exp_addr = exp_addr + 16'd2;
   endtask

   task automatic send(input req_t r, input logic ld, input logic [15:0] la);
      int k;
      k = 0;
      while (!in_ready && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      mnem = r.m; smod = r.sm; sreg = r.sr; dmod = r.dm; dreg = r.dr;
      src_x = r.sx; dst_x = r.dx; br_ofst = r.bo;
      in_valid = 1'b1; addr_load = ld; addr_in = la;
      @(posedge clk);
      if (ld) exp_addr = la & 16'hFFFE;
      if (r.n > 0) push_word(r.w0, r.n == 1);
      if (r.n > 1) push_word(r.w1, r.n == 2);
      if (r.n > 2) push_word(r.w2, 1'b1);
      #1;
      in_valid = 1'b0; addr_load = 1'b0;
      mnem = opcode_mnemonic'(7'($urandom_range(0, 64)));
      smod = 3'($urandom); sreg = 3'($urandom); dmod = 3'($urandom); dreg = 3'($urandom);
      src_x = 16'($urandom); dst_x = 16'($urandom); br_ofst = 8'($urandom); addr_in = 16'($urandom);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((sbq.size() != 0 || !in_ready) && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      if (sbq.size() != 0 || !in_ready) begin
         total++; bad++;
         $display("FAIL drain_timeout: pending=%0d in_ready=%0d expected 0 and 1", sbq.size(), in_ready);
         sbq.delete();
      end
   endtask

   always @(negedge clk) begin
      if (err === 1'b1) err_cnt++;
      if (!reset && out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_word: got %06o at %06o expected none", out_data, out_addr);
         end else begin
            mon_e = sbq.pop_front();
            chk("word_data", out_data, mon_e.data);
            chk("word_addr", out_addr, mon_e.addr);
            chk("word_last", {15'b0, out_last}, {15'b0, mon_e.last});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl.push_back(mk(M_MOV,  3'o0, 3'o1, 3'o0, 3'o2, 16'o0,    16'o0,    8'h00, 1, 16'o010102, 16'o0, 16'o0));
      tbl.push_back(mk(M_ADD,  3'o2, 3'o7, 3'o6, 3'o3, 16'o5,    16'o12,   8'h00, 3, 16'o062763, 16'o000005, 16'o000012));
      tbl.push_back(mk(M_BNE,  3'o0, 3'o0, 3'o0, 3'o0, 16'o0,    16'o0,    8'hFE, 1, 16'o001376, 16'o0, 16'o0));
      tbl.push_back(mk(M_SEN,  3'o0, 3'o0, 3'o0, 3'o0, 16'o0,    16'o0,    8'h00, 1, 16'o000270, 16'o0, 16'o0));
      tbl.push_back(mk(M_RTS,  3'o2, 3'o7, 3'o6, 3'o5, 16'o7,    16'o7,    8'h33, 1, 16'o000205, 16'o0, 16'o0));
      tbl.push_back(mk(M_JSR,  3'o0, 3'o5, 3'o3, 3'o4, 16'o0,    16'o0,    8'h00, 1, 16'o004534, 16'o0, 16'o0));
      tbl.push_back(mk(M_SUB,  3'o0, 3'o0, 3'o4, 3'o6, 16'o0,    16'o0,    8'h00, 1, 16'o160046, 16'o0, 16'o0));
      tbl.push_back(mk(M_CMPB, 3'o6, 3'o2, 3'o0, 3'o1, 16'o6,    16'o0,    8'h00, 2, 16'o126201, 16'o000006, 16'o0));
      tbl.push_back(mk(M_INC,  3'o0, 3'o0, 3'o0, 3'o3, 16'o0,    16'o0,    8'h00, 1, 16'o005203, 16'o0, 16'o0));
      tbl.push_back(mk(M_SWAB, 3'o0, 3'o0, 3'o7, 3'o7, 16'o0,    16'o1234, 8'h00, 2, 16'o000377, 16'o001234, 16'o0));
      tbl.push_back(mk(M_HALT, 3'o0, 3'o0, 3'o0, 3'o0, 16'o0,    16'o0,    8'h00, 1, 16'o000000, 16'o0, 16'o0));
      tbl.push_back(mk(M_NOP,  3'o0, 3'o0, 3'o0, 3'o0, 16'o0,    16'o0,    8'h00, 1, 16'o000240, 16'o0, 16'o0));
      tbl.push_back(mk(M_BPL,  3'o0, 3'o0, 3'o0, 3'o0, 16'o0,    16'o0,    8'h05, 1, 16'o100005, 16'o0, 16'o0));
      tbl.push_back(mk(M_JMP,  3'o0, 3'o0, 3'o1, 3'o2, 16'o0,    16'o0,    8'h00, 1, 16'o000112, 16'o0, 16'o0));
      tbl.push_back(mk(M_ASLB, 3'o0, 3'o0, 3'o0, 3'o4, 16'o0,    16'o0,    8'h00, 1, 16'o106304, 16'o0, 16'o0));
      tbl.push_back(mk(M_MOV,  3'o2, 3'o7, 3'o3, 3'o7, 16'o1234, 16'o2000, 8'h00, 3, 16'o012737, 16'o001234, 16'o002000));
      tbl.push_back(mk(M_BIC,  3'o0, 3'o3, 3'o0, 3'o4, 16'o0,    16'o0,    8'h00, 1, 16'o040304, 16'o0, 16'o0));
      tbl.push_back(mk(M_CLC,  3'o0, 3'o0, 3'o0, 3'o0, 16'o0,    16'o0,    8'h00, 1, 16'o000241, 16'o0, 16'o0));

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {15'b0, out_valid}, 16'd0);
      chk("rst_out_data",  out_data, 16'd0);
      chk("rst_out_last",  {15'b0, out_last}, 16'd0);
      chk("rst_err",       {15'b0, err}, 16'd0);
      chk("rst_out_addr",  out_addr, 16'o000000);
      chk("rst_in_ready",  {15'b0, in_ready}, 16'd1);
      exp_addr = 16'o000000;
      @(posedge clk); #1;

      // First request also loads an odd address: bit 0 must be dropped.
      for (int i = 0; i < tbl.size(); i++) begin
         send(tbl[i], i == 0, 16'o001001);
         wait_idle();
      end

      a0 = exp_addr;
      send(tbl[1], 1'b0, 16'd0);
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stall_valid", {15'b0, out_valid}, 16'd1);
         chk("stall_data", out_data, 16'o000005);
         chk("stall_addr", out_addr, a0 + 16'd2);
         chk("stall_last", {15'b0, out_last}, 16'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      wait_idle();

      send(mk(M_JMP, 3'o0, 3'o0, 3'o0, 3'o3, 16'o0, 16'o0, 8'h00, 0, 16'o0, 16'o0, 16'o0), 1'b0, 16'd0);
      @(negedge clk);
      chk("illegal_err_hi", {15'b0, err}, 16'd1);
      chk("illegal_no_valid0", {15'b0, out_valid}, 16'd0);
      @(negedge clk);
      chk("illegal_err_lo", {15'b0, err}, 16'd0);
      chk("illegal_no_valid1", {15'b0, out_valid}, 16'd0);
      @(posedge clk); #1;
      send(tbl[0], 1'b0, 16'd0);
      wait_idle();

      send(tbl[15], 1'b0, 16'd0);
      addr_load = 1'b1;
      addr_in = 16'o002000;
      @(posedge clk);
      @(posedge clk); #1;
      addr_load = 1'b0;
      wait_idle();

      addr_load = 1'b1;
      addr_in = 16'o177776;
      @(posedge clk); #1;
      addr_load = 1'b0;
      exp_addr = 16'o177776;
      send(mk(M_CLRB, 3'o0, 3'o0, 3'o3, 3'o7, 16'o0, 16'o100, 8'h00, 2, 16'o105037, 16'o000100, 16'o0), 1'b0, 16'd0);
      wait_idle();

      out_ready = 1'b0;
      send(tbl[1], 1'b0, 16'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      reset = 1'b1;
      #1;
      chk("pend_src_data", out_data, 16'o000005);
      @(posedge clk);
      @(negedge clk);
      chk("midrst_out_valid", {15'b0, out_valid}, 16'd0);
      chk("midrst_in_ready", {15'b0, in_ready}, 16'd1);
      chk("midrst_out_addr", out_addr, 16'o000000);
      sbq.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      out_ready = 1'b1;
      exp_addr = 16'o000000;
      send(tbl[11], 1'b0, 16'd0);
      wait_idle();

      repeat (3) @(posedge clk);
      #1;
      chk("err_pulse_count", 16'(err_cnt), 16'd1);
      chk("scoreboard_empty", 16'(sbq.size()), 16'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
